zbt_point_loader: RTL and testbench

- Sequencer that sits directly upstream of the ZBT write path and drives the 2-bit point-table index.
- Steps the index 0..NUM_POINTS-1 and captures each 36-bit point word {6'b0, x[9:0], y[9:0], intensity[9:0]} returned by the combinational point table.
- Issues one write per point into consecutive ZBT addresses starting at BASE_ADDR, honouring a per-cycle memory grant shared with the display read path.
- Reports busy/done to the top-level control FSM.

---
 rtl/zbt_point_loader.sv | 144 ++++++++++++++
 tb/tb_zbt_point_loader.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zbt_point_loader.sv
// Point-table loader: steps the 2-bit table index, captures each 36-bit point
// word and writes it to consecutive ZBT addresses starting at BASE_ADDR.
module zbt_point_loader #(
  parameter int unsigned            NUM_POINTS = 4,
  parameter int unsigned            ADDR_WIDTH = 19,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [1:0]            index,
  input  logic [35:0]           value,
  input  logic                  mem_grant,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [35:0]           mem_data,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            dbg_state
);

  // Memory handshake: mem_grant acts as "ready" and is sampled only while in
  // S_WAIT_GRANT; a sampled grant commits the write, and mem_we/mem_addr/
  // mem_data are presented for exactly the following cycle. Without a grant
  // the loader waits indefinitely with everything held.
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SETUP      = 3'd1,
    S_CAPTURE    = 3'd2,
    S_WAIT_GRANT = 3'd3,
    S_WRITE      = 3'd4,
    S_DONE       = 3'd5
  } state_e;

  localparam logic [1:0] LAST_IDX = 2'(NUM_POINTS - 1);

  state_e                state_q, state_d;
  logic [1:0]            count_q, count_d;
  logic [1:0]            index_q, index_d;
  logic [35:0]           data_reg_q, data_reg_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [35:0]           mem_data_q, mem_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    index_d    = index_q;
    data_reg_d = data_reg_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          count_d = 2'd0;
          index_d = 2'd0;
          busy_d  = 1'b1;
        end
      end
      S_SETUP: begin
        // Table output is combinational from index; give it a cycle to settle.
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        data_reg_d = value;
        state_d    = S_WAIT_GRANT;
      end
      S_WAIT_GRANT: begin
        if (mem_grant) begin
          mem_we_d   = 1'b1;
          mem_addr_d = BASE_ADDR + ADDR_WIDTH'(count_q);
          mem_data_d = data_reg_q;
          state_d    = S_WRITE;
        end
      end
      S_WRITE: begin
        if (count_q == LAST_IDX) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          count_d = count_q + 2'd1;
          index_d = count_q + 2'd1;
          state_d = S_SETUP;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= 2'd0;
      index_q    <= 2'd0;
      data_reg_q <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      index_q    <= index_d;
      data_reg_q <= data_reg_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign index     = index_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

  // Structural invariants of the write sequencing.
  a_no_back_to_back_we: assert property (@(posedge clk) disable iff (reset)
    mem_we_q |=> !mem_we_q);
  a_index_in_range: assert property (@(posedge clk) disable iff (reset)
    index_q <= LAST_IDX);
  a_done_not_with_we: assert property (@(posedge clk) disable iff (reset)
    !(done_q && mem_we_q));

endmodule

// File: tb/tb_zbt_point_loader.sv
// Self-checking bench for zbt_point_loader: a default instance and a
// two-point instance at BASE_ADDR 0x100 share clock, reset, start and grant.
module tb_zbt_point_loader;
  localparam int AW = 19;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          start = 1'b0;
  logic          mem_grant = 1'b0;
  logic [1:0]    index, index2;
  logic [35:0]   value, value2;
  logic          mem_we, mem_we2;
  logic [AW-1:0] mem_addr, mem_addr2;
  logic [35:0]   mem_data, mem_data2;
  logic          busy, busy2, done, done2;
  logic [2:0]    dbg_state, dbg_state2;

  // Behavioural point table; glitch replaces the table output with noise.
  logic [35:0] tbl [4];
  logic        glitch = 1'b0;
  logic [35:0] noise = '0;
  assign value  = glitch ? noise : tbl[index];
  assign value2 = tbl[index2];

  zbt_point_loader dut (
    .clk(clk), .reset(reset), .start(start), .index(index), .value(value),
    .mem_grant(mem_grant), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  zbt_point_loader #(.NUM_POINTS(2), .ADDR_WIDTH(AW), .BASE_ADDR(19'h100)) dut2 (
    .clk(clk), .reset(reset), .start(start), .index(index2), .value(value2),
    .mem_grant(mem_grant), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_data(mem_data2), .busy(busy2), .done(done2), .dbg_state(dbg_state2)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int grant_mode = 0;  // 0 high, 1 toggle, 2 low, 3 random

  // ---------------- monitor ----------------
  logic          g_sampled = 1'b0;
  logic          prev_we = 1'b0;
  logic [AW-1:0] obs_addr[$];
  logic [35:0]   obs_data[$];
  int            obs_cyc[$];
  int            done_cyc[$];
  logic [AW-1:0] obs2_addr[$];
  logic [35:0]   obs2_data[$];
  int            done2_n = 0;
  int            b2b = 0;
  int            nogrant = 0;
  int            idx2_over = 0;

  always @(posedge clk) g_sampled <= mem_grant;

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        obs_addr.push_back(mem_addr);
        obs_data.push_back(mem_data);
        obs_cyc.push_back(cyc);
        if (prev_we) b2b++;
        if (!g_sampled) nogrant++;
      end
      if (done) done_cyc.push_back(cyc);
      if (mem_we2) begin
        obs2_addr.push_back(mem_addr2);
        obs2_data.push_back(mem_data2);
      end
      if (done2) done2_n++;
      if (index2 > 2'd1) idx2_over++;
    end
    prev_we <= mem_we;
  end

  // ---------------- reference model ----------------
  logic [AW+35:0] exp_q[$];

  function automatic void build_exp(input int n, input logic [AW-1:0] base);
    exp_q = {};
    for (int i = 0; i < n; i++) exp_q.push_back({base + AW'(i), tbl[i]});
  endfunction

  // ---------------- drivers ----------------
  task automatic step(input bit s);
    @(negedge clk);
    start = s;
    noise = 36'({$urandom(), $urandom()});
    case (grant_mode)
      0: mem_grant = 1'b1;
      1: mem_grant = ~mem_grant;
      2: mem_grant = 1'b0;
      default: mem_grant = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int k = 0; k < budget; k++) begin
      step(1'b0);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete(); done_cyc.delete();
    obs2_addr.delete(); obs2_data.delete();
    done2_n = 0; b2b = 0; nogrant = 0; idx2_over = 0;
  endtask

  task automatic load_plan_table();
    tbl[0] = {6'b0, 10'd300, 10'd300, 10'b1111111100};
    tbl[1] = {6'b0, 10'd400, 10'd400, 10'b0111111100};
    tbl[2] = {6'b0, 10'd500, 10'd500, 10'b0011111100};
    tbl[3] = {6'b0, 10'd600, 10'd600, 10'b0001111100};
  endtask

  task automatic load_random_table();
    for (int i = 0; i < 4; i++) tbl[i] = {6'b0, 30'($urandom())};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    load_plan_table();
    reset = 1'b1;
    repeat (3) step(1'b0);
    n_checks++;
    if ({index, mem_we, mem_addr, mem_data, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got idx=%0d we=%b addr=%h data=%h busy=%b done=%b, want all 0",
               index, mem_we, mem_addr, mem_data, busy, done);
    end
    n_checks++;
    if ({index2, mem_we2, mem_addr2, mem_data2, busy2, done2} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs2: got idx=%0d we=%b addr=%h busy=%b done=%b, want all 0",
               index2, mem_we2, mem_addr2, busy2, done2);
    end
    reset = 1'b0;
    repeat (2) step(1'b0);
  endtask

  task automatic test_grant_high();
    int c_start;
    bit to;
    logic [AW+35:0] got;
    load_plan_table();
    grant_mode = 0;
    clear_obs();
    step(1'b1);
    c_start = cyc;
    wait_done(200, to);
    repeat (3) step(1'b0);
    build_exp(4, '0);
    n_checks++;
    if (to || obs_addr.size() != 4) begin
      n_fail++;
      $display("FAIL grant_high_count: got %0d writes (timeout=%b), want 4", obs_addr.size(), to);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = '1;
      if (i < obs_addr.size()) got = {obs_addr[i], obs_data[i]};
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL grant_high_write%0d: got %h, want %h", i, got, exp_q[i]);
      end
    end
    if (obs_cyc.size() == 4) begin
      n_checks++;
      if (obs_cyc[0] - c_start != 4) begin
        n_fail++;
        $display("FAIL grant_high_latency: got %0d cycles, want 4", obs_cyc[0] - c_start);
      end
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (obs_cyc[i] - obs_cyc[i-1] != 4) begin
          n_fail++;
          $display("FAIL grant_high_spacing%0d: got %0d cycles, want 4", i, obs_cyc[i] - obs_cyc[i-1]);
        end
      end
      n_checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != obs_cyc[3] + 1) begin
        n_fail++;
        $display("FAIL grant_high_done: got %0d done pulses (first at %0d), want 1 at %0d",
                 done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, obs_cyc[3] + 1);
      end
    end
    n_checks++;
    if (busy !== 1'b0 || index !== 2'd3) begin
      n_fail++;
      $display("FAIL grant_high_after: got busy=%b index=%0d, want busy=0 index=3", busy, index);
    end
  endtask

  task automatic test_grant_toggle();
    bit to;
    logic [AW+35:0] got;
    load_random_table();
    grant_mode = 1;
    clear_obs();
    step(1'b1);
    wait_done(300, to);
    repeat (3) step(1'b0);
    build_exp(4, '0);
    n_checks++;
    if (to || obs_addr.size() != 4 || done_cyc.size() != 1) begin
      n_fail++;
      $display("FAIL toggle_count: got %0d writes %0d dones (timeout=%b), want 4 and 1",
               obs_addr.size(), done_cyc.size(), to);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = '1;
      if (i < obs_addr.size()) got = {obs_addr[i], obs_data[i]};
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL toggle_write%0d: got %h, want %h", i, got, exp_q[i]);
      end
    end
    n_checks++;
    if (nogrant != 0 || b2b != 0) begin
      n_fail++;
      $display("FAIL toggle_we_rules: got %0d ungranted and %0d back-to-back strobes, want 0 and 0",
               nogrant, b2b);
    end
  endtask

  task automatic test_grant_stall();
    bit to;
    int seen;
    int bad;
    logic [AW+35:0] got;
    load_random_table();
    grant_mode = 0;
    clear_obs();
    step(1'b1);
    seen = 0;
    for (int k = 0; k < 100 && seen < 2; k++) begin
      step(1'b0);
      if (mem_we) seen++;
    end
    grant_mode = 2;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0);
      if (k == 5) glitch = 1'b1;
      if (index !== 2'd2 || busy !== 1'b1 || mem_we !== 1'b0) bad++;
    end
    n_checks++;
    if (seen != 2 || bad != 0 || obs_addr.size() != 2) begin
      n_fail++;
      $display("FAIL stall_hold: got %0d bad cycles, %0d writes, index=%0d busy=%b, want 0, 2, 2, 1",
               bad, obs_addr.size(), index, busy);
    end
    glitch = 1'b0;
    grant_mode = 0;
    wait_done(200, to);
    repeat (3) step(1'b0);
    build_exp(4, '0);
    n_checks++;
    if (to || obs_addr.size() != 4) begin
      n_fail++;
      $display("FAIL stall_count: got %0d writes (timeout=%b), want 4", obs_addr.size(), to);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = '1;
      if (i < obs_addr.size()) got = {obs_addr[i], obs_data[i]};
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stall_write%0d: got %h, want %h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    bit to;
    logic [AW+35:0] got;
    load_plan_table();
    grant_mode = 3;
    clear_obs();
    step(1'b1);
    repeat (6) step(1'b0);
    step(1'b1);
    to = 1'b1;
    for (int k = 0; k < 400; k++) begin
      step(1'b0);
      if (done) begin
        start = 1'b1;
        to = 1'b0;
        break;
      end
    end
    repeat (10) step(1'b0);
    n_checks++;
    if (to || obs_addr.size() != 4 || done_cyc.size() != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_start: got %0d writes %0d dones busy=%b (timeout=%b), want 4, 1, 0",
               obs_addr.size(), done_cyc.size(), busy, to);
    end
    clear_obs();
    step(1'b1);
    wait_done(400, to);
    repeat (3) step(1'b0);
    build_exp(4, '0);
    n_checks++;
    if (to || obs_addr.size() != 4 || done_cyc.size() != 1) begin
      n_fail++;
      $display("FAIL second_run_count: got %0d writes %0d dones (timeout=%b), want 4 and 1",
               obs_addr.size(), done_cyc.size(), to);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = '1;
      if (i < obs_addr.size()) got = {obs_addr[i], obs_data[i]};
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL second_run_write%0d: got %h, want %h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit to;
    int seen;
    logic [AW+35:0] got;
    load_random_table();
    grant_mode = 0;
    clear_obs();
    step(1'b1);
    seen = 0;
    for (int k = 0; k < 100 && seen < 1; k++) begin
      step(1'b0);
      if (mem_we) seen++;
    end
    grant_mode = 2;
    repeat (5) step(1'b0);
    reset = 1'b1;
    #1;
    n_checks++;
    if (seen != 1 || {index, mem_we, mem_addr, mem_data, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got idx=%0d we=%b addr=%h data=%h busy=%b done=%b, want all 0",
               index, mem_we, mem_addr, mem_data, busy, done);
    end
    clear_obs();
    repeat (2) step(1'b0);
    reset = 1'b0;
    grant_mode = 0;
    repeat (12) step(1'b0);
    n_checks++;
    if (obs_addr.size() != 0 || done_cyc.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_quiet: got %0d writes %0d dones busy=%b, want 0, 0, 0",
               obs_addr.size(), done_cyc.size(), busy);
    end
    step(1'b1);
    wait_done(200, to);
    repeat (3) step(1'b0);
    build_exp(4, '0);
    n_checks++;
    if (to || obs_addr.size() != 4) begin
      n_fail++;
      $display("FAIL restart_count: got %0d writes (timeout=%b), want 4", obs_addr.size(), to);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = '1;
      if (i < obs_addr.size()) got = {obs_addr[i], obs_data[i]};
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL restart_write%0d: got %h, want %h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_params();
    bit to;
    logic [AW+35:0] got;
    load_random_table();
    grant_mode = 1;
    repeat (5) step(1'b0);
    clear_obs();
    step(1'b1);
    to = 1'b1;
    for (int k = 0; k < 200; k++) begin
      step(1'b0);
      if (done2) begin
        to = 1'b0;
        break;
      end
    end
    repeat (4) step(1'b0);
    build_exp(2, 19'h100);
    n_checks++;
    if (to || obs2_addr.size() != 2 || done2_n != 1) begin
      n_fail++;
      $display("FAIL params_count: got %0d writes %0d dones (timeout=%b), want 2 and 1",
               obs2_addr.size(), done2_n, to);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = '1;
      if (i < obs2_addr.size()) got = {obs2_addr[i], obs2_data[i]};
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL params_write%0d: got %h, want %h", i, got, exp_q[i]);
      end
    end
    n_checks++;
    if (idx2_over != 0 || index2 !== 2'd1) begin
      n_fail++;
      $display("FAIL params_index: got %0d over-range cycles, final index=%0d, want 0 and 1",
               idx2_over, index2);
    end
    wait_done(200, to);
    repeat (3) step(1'b0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_grant_high();
    test_grant_toggle();
    test_grant_stall();
    test_start_ignored();
    test_mid_reset();
    test_params();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before the end of the sequence");
    $fatal(1, "watchdog");
  end

endmodule
